// File: rtl/interrupt_request_ctrl.sv
// interrupt_request_ctrl
// Front end of the reset/NMI/IRQ path. It samples the nRES/nNMI/nIRQ pins,
// arms a reset after nRES has been held low long enough, and hands
// prioritised NMI/IRQ requests with their vector address to the instruction
// sequencer at instruction boundaries.
//
// Build option: define INTERRUPT_PIN_SYNC_EN to pass each pin through
// SYNC_STAGES flops. Without it every pin passes through a single flop, which
// suits harnesses that drive the pins synchronously.
//
// Request/acknowledge handshake: interruptRequest rises together with a valid
// vectorAddr. Both stay stable while the controller sits in SERVICE. The
// sequencer ends service by raising interruptAck for one enabled cycle, and
// interruptRequest drops after that edge. An interruptAck outside SERVICE is
// ignored. The controller state is held in the enum signal 'state' so checkers
// can bind to it.

module interrupt_request_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int RES_HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enableFFs,
  input  logic        nResPin,
  input  logic        nNmiPin,
  input  logic        nIrqPin,
  input  logic        processStatusRegIFlag,
  input  logic        resetRunning,
  input  logic        instructionBoundary,
  input  logic        interruptAck,
  output logic        resetInitiated,
  output logic        interruptRequest,
  output logic        nmiPending,
  output logic [15:0] vectorAddr
);

  // Both depths must be at least one; reject bad builds at elaboration.
  if (SYNC_STAGES < 1 || RES_HOLD_CYCLES < 1) begin : gBadParams
    $error("interrupt_request_ctrl: SYNC_STAGES and RES_HOLD_CYCLES must be >= 1");
  end

`ifdef INTERRUPT_PIN_SYNC_EN
  localparam int STAGES = SYNC_STAGES;
`else
  localparam int STAGES = 1;
`endif

  localparam int          CW       = $clog2(RES_HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(RES_HOLD_CYCLES);

  localparam logic [15:0] VEC_RES = 16'hFFFC;
  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVICE  = 2'd1,
    RES_HOLD = 2'd2
  } stateType;

  stateType          state;
  logic [CW-1:0]     holdCnt;
  logic [CW-1:0]     holdNext;
  logic [STAGES-1:0] resShift;
  logic [STAGES-1:0] nmiShift;
  logic [STAGES-1:0] irqShift;
  logic              resSync;
  logic              nmiSync;
  logic              irqSync;
  logic              nmiPrev;
  logic              nmiEdge;
  logic              resArm;
  logic              irqActive;
  logic              nmiClear;

  assign resSync = resShift[STAGES-1];
  assign nmiSync = nmiShift[STAGES-1];
  assign irqSync = irqShift[STAGES-1];

  // Pin synchronisers and NMI edge register run every cycle, ignoring the stall.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      resShift <= '1;
      nmiShift <= '1;
      irqShift <= '1;
      nmiPrev  <= 1'b1;
    end else begin
      resShift[0] <= nResPin;
      nmiShift[0] <= nNmiPin;
      irqShift[0] <= nIrqPin;
      for (int i = 1; i < STAGES; i++) begin
        resShift[i] <= resShift[i-1];
        nmiShift[i] <= nmiShift[i-1];
        irqShift[i] <= irqShift[i-1];
      end
      nmiPrev <= nmiSync;
    end
  end

  assign nmiEdge   = nmiPrev && !nmiSync;
  assign irqActive = !irqSync && !processStatusRegIFlag;

  // Next hold count: saturating count of enabled cycles with nRES low.
  always_comb begin
    holdNext = holdCnt;
    if (resSync) begin
      holdNext = '0;
    end else if (holdCnt != HOLD_MAX) begin
      holdNext = holdCnt + 1'b1;
    end
  end

  // A reset is armed on any enabled cycle that leaves the counter saturated.
  assign resArm = !resSync && (holdNext == HOLD_MAX);

  // NMI service ends, or a reset is armed: the pending NMI is consumed.
  assign nmiClear = enableFFs &&
                    (resArm ||
                     (state == SERVICE && interruptAck && vectorAddr == VEC_NMI));

  // Sticky NMI latch; a fresh edge beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      nmiPending <= 1'b0;
    end else begin
      nmiPending <= (nmiPending && !nmiClear) || nmiEdge;
    end
  end

  // Controller FSM with registered outputs; advances only on enabled cycles.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state            <= RES_HOLD;
      holdCnt          <= HOLD_MAX;
      resetInitiated   <= 1'b0;
      interruptRequest <= 1'b0;
      vectorAddr       <= VEC_RES;
    end else if (!enableFFs) begin
      // A stall must not stretch the reset pulse into a second cycle.
      resetInitiated <= 1'b0;
    end else begin
      holdCnt        <= holdNext;
      resetInitiated <= 1'b0;
      if (resArm) begin
        state            <= RES_HOLD;
        interruptRequest <= 1'b0;
        vectorAddr       <= VEC_RES;
      end else begin
        case (state)
          RES_HOLD: begin
            if (resSync) begin
              resetInitiated <= 1'b1;
              state          <= IDLE;
            end
          end
          IDLE: begin
            if (instructionBoundary && !resetRunning && (nmiPending || irqActive)) begin
              state            <= SERVICE;
              interruptRequest <= 1'b1;
              vectorAddr       <= nmiPending ? VEC_NMI : VEC_IRQ;
            end
          end
          SERVICE: begin
            if (interruptAck) begin
              state            <= IDLE;
              interruptRequest <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_interrupt_request_ctrl.sv
// Directed self-checking bench for interrupt_request_ctrl (default parameters).
// Inputs change 1 ns after each rising edge; outputs are checked at that point.

module tb_interrupt_request_ctrl;

`ifdef INTERRUPT_PIN_SYNC_EN
  localparam int EFF_STAGES = 2;
`else
  localparam int EFF_STAGES = 1;
`endif

  logic        clk;
  logic        nrst;
  logic        enableFFs;
  logic        nResPin;
  logic        nNmiPin;
  logic        nIrqPin;
  logic        processStatusRegIFlag;
  logic        resetRunning;
  logic        instructionBoundary;
  logic        interruptAck;
  logic        resetInitiated;
  logic        interruptRequest;
  logic        nmiPending;
  logic [15:0] vectorAddr;

  int testsRun;
  int testsFailed;

  interrupt_request_ctrl dut (
    .clk                   (clk),
    .nrst                  (nrst),
    .enableFFs             (enableFFs),
    .nResPin               (nResPin),
    .nNmiPin               (nNmiPin),
    .nIrqPin               (nIrqPin),
    .processStatusRegIFlag (processStatusRegIFlag),
    .resetRunning          (resetRunning),
    .instructionBoundary   (instructionBoundary),
    .interruptAck          (interruptAck),
    .resetInitiated        (resetInitiated),
    .interruptRequest      (interruptRequest),
    .nmiPending            (nmiPending),
    .vectorAddr            (vectorAddr)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle low pulse on nNmiPin; pending becomes visible after the second edge.
  task automatic pulse_nmi();
    nNmiPin = 1'b0;
    tick();
    nNmiPin = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) tick();
    testsRun++; if (resetInitiated !== 1'b0) begin testsFailed++; $display("FAIL rst_resetInitiated: got %b want 0", resetInitiated); end
    testsRun++; if (interruptRequest !== 1'b0) begin testsFailed++; $display("FAIL rst_interruptRequest: got %b want 0", interruptRequest); end
    testsRun++; if (nmiPending !== 1'b0) begin testsFailed++; $display("FAIL rst_nmiPending: got %b want 0", nmiPending); end
    testsRun++; if (vectorAddr !== 16'hFFFC) begin testsFailed++; $display("FAIL rst_vectorAddr: got %h want FFFC", vectorAddr); end
    nrst = 1'b1;
    tick();
    testsRun++; if (resetInitiated !== 1'b1) begin testsFailed++; $display("FAIL por_pulse: got %b want 1", resetInitiated); end
    testsRun++; if (vectorAddr !== 16'hFFFC) begin testsFailed++; $display("FAIL por_vector: got %h want FFFC", vectorAddr); end
    tick();
    testsRun++; if (resetInitiated !== 1'b0) begin testsFailed++; $display("FAIL por_pulse_end: got %b want 0", resetInitiated); end
  endtask

  task automatic test_res_glitch();
    nResPin = 1'b0;
    tick();
    nResPin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      testsRun++; if (resetInitiated !== 1'b0) begin testsFailed++; $display("FAIL res_glitch_cycle%0d: resetInitiated=%b want 0", i, resetInitiated); end
    end
  endtask

  task automatic test_res_long();
    pulse_nmi();
    testsRun++; if (nmiPending !== 1'b1) begin testsFailed++; $display("FAIL res_long_pre_nmi: nmiPending=%b want 1", nmiPending); end
    nResPin = 1'b0;
    repeat (4) tick();
    testsRun++; if (nmiPending !== 1'b0) begin testsFailed++; $display("FAIL res_long_nmi_cleared: nmiPending=%b want 0", nmiPending); end
    testsRun++; if (vectorAddr !== 16'hFFFC) begin testsFailed++; $display("FAIL res_long_vector: got %h want FFFC", vectorAddr); end
    testsRun++; if (resetInitiated !== 1'b0) begin testsFailed++; $display("FAIL res_long_held: resetInitiated=%b want 0", resetInitiated); end
    nResPin = 1'b1;
    for (int i = 0; i < EFF_STAGES; i++) begin
      tick();
      testsRun++; if (resetInitiated !== 1'b0) begin testsFailed++; $display("FAIL res_long_early%0d: resetInitiated=%b want 0", i, resetInitiated); end
    end
    tick();
    testsRun++; if (resetInitiated !== 1'b1) begin testsFailed++; $display("FAIL res_long_pulse: resetInitiated=%b want 1", resetInitiated); end
    tick();
    testsRun++; if (resetInitiated !== 1'b0) begin testsFailed++; $display("FAIL res_long_single: resetInitiated=%b want 0", resetInitiated); end
  endtask

  task automatic test_nmi_stalled();
    enableFFs = 1'b0;
    pulse_nmi();
    testsRun++; if (nmiPending !== 1'b1) begin testsFailed++; $display("FAIL nmi_stall_pending: got %b want 1", nmiPending); end
    instructionBoundary = 1'b1;
    tick();
    testsRun++; if (interruptRequest !== 1'b0) begin testsFailed++; $display("FAIL nmi_stall_hold: interruptRequest=%b want 0", interruptRequest); end
    enableFFs = 1'b1;
    tick();
    instructionBoundary = 1'b0;
    testsRun++; if (interruptRequest !== 1'b1) begin testsFailed++; $display("FAIL nmi_req: got %b want 1", interruptRequest); end
    testsRun++; if (vectorAddr !== 16'hFFFA) begin testsFailed++; $display("FAIL nmi_vector: got %h want FFFA", vectorAddr); end
    tick();
    testsRun++; if (interruptRequest !== 1'b1) begin testsFailed++; $display("FAIL nmi_req_held: got %b want 1", interruptRequest); end
    interruptAck = 1'b1;
    tick();
    interruptAck = 1'b0;
    testsRun++; if (interruptRequest !== 1'b0) begin testsFailed++; $display("FAIL nmi_ack_req: got %b want 0", interruptRequest); end
    testsRun++; if (nmiPending !== 1'b0) begin testsFailed++; $display("FAIL nmi_ack_pending: got %b want 0", nmiPending); end
  endtask

  task automatic test_irq_masked();
    processStatusRegIFlag = 1'b1;
    nIrqPin = 1'b0;
    instructionBoundary = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      testsRun++; if (interruptRequest !== 1'b0) begin testsFailed++; $display("FAIL irq_masked%0d: interruptRequest=%b want 0", i, interruptRequest); end
    end
    processStatusRegIFlag = 1'b0;
    tick();
    instructionBoundary = 1'b0;
    testsRun++; if (interruptRequest !== 1'b1) begin testsFailed++; $display("FAIL irq_req: got %b want 1", interruptRequest); end
    testsRun++; if (vectorAddr !== 16'hFFFE) begin testsFailed++; $display("FAIL irq_vector: got %h want FFFE", vectorAddr); end
  endtask

  task automatic test_nmi_during_irq();
    nIrqPin = 1'b1;
    processStatusRegIFlag = 1'b1;
    pulse_nmi();
    testsRun++; if (nmiPending !== 1'b1) begin testsFailed++; $display("FAIL nmi_in_irq_pending: got %b want 1", nmiPending); end
    testsRun++; if (vectorAddr !== 16'hFFFE) begin testsFailed++; $display("FAIL nmi_in_irq_vector: got %h want FFFE", vectorAddr); end
    testsRun++; if (interruptRequest !== 1'b1) begin testsFailed++; $display("FAIL nmi_in_irq_req: got %b want 1", interruptRequest); end
    interruptAck = 1'b1;
    tick();
    interruptAck = 1'b0;
    testsRun++; if (interruptRequest !== 1'b0) begin testsFailed++; $display("FAIL irq_ack_req: got %b want 0", interruptRequest); end
    testsRun++; if (nmiPending !== 1'b1) begin testsFailed++; $display("FAIL irq_ack_keeps_nmi: got %b want 1", nmiPending); end
    instructionBoundary = 1'b1;
    tick();
    instructionBoundary = 1'b0;
    testsRun++; if (vectorAddr !== 16'hFFFA) begin testsFailed++; $display("FAIL nmi_after_irq_vector: got %h want FFFA", vectorAddr); end
    testsRun++; if (interruptRequest !== 1'b1) begin testsFailed++; $display("FAIL nmi_after_irq_req: got %b want 1", interruptRequest); end
    interruptAck = 1'b1;
    tick();
    interruptAck = 1'b0;
    testsRun++; if (nmiPending !== 1'b0) begin testsFailed++; $display("FAIL nmi_after_irq_cleared: got %b want 0", nmiPending); end
  endtask

  task automatic test_reset_running();
    pulse_nmi();
    resetRunning = 1'b1;
    instructionBoundary = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      testsRun++; if (interruptRequest !== 1'b0) begin testsFailed++; $display("FAIL resrun_block%0d: interruptRequest=%b want 0", i, interruptRequest); end
    end
    testsRun++; if (nmiPending !== 1'b1) begin testsFailed++; $display("FAIL resrun_pending: got %b want 1", nmiPending); end
    resetRunning = 1'b0;
    tick();
    instructionBoundary = 1'b0;
    testsRun++; if (interruptRequest !== 1'b1) begin testsFailed++; $display("FAIL resrun_release_req: got %b want 1", interruptRequest); end
    testsRun++; if (vectorAddr !== 16'hFFFA) begin testsFailed++; $display("FAIL resrun_release_vector: got %h want FFFA", vectorAddr); end
    interruptAck = 1'b1;
    tick();
    interruptAck = 1'b0;
    testsRun++; if (interruptRequest !== 1'b0) begin testsFailed++; $display("FAIL resrun_ack: got %b want 0", interruptRequest); end
  endtask

  task automatic test_back_to_back();
    pulse_nmi();
    instructionBoundary = 1'b1;
    tick();
    instructionBoundary = 1'b0;
    testsRun++; if (interruptRequest !== 1'b1) begin testsFailed++; $display("FAIL b2b_first_req: got %b want 1", interruptRequest); end
    // New NMI edge lands on the same edge as the ack of the current NMI.
    nNmiPin = 1'b0;
    tick();
    nNmiPin = 1'b1;
    interruptAck = 1'b1;
    tick();
    interruptAck = 1'b0;
    testsRun++; if (interruptRequest !== 1'b0) begin testsFailed++; $display("FAIL b2b_ack_req: got %b want 0", interruptRequest); end
    testsRun++; if (nmiPending !== 1'b1) begin testsFailed++; $display("FAIL b2b_set_wins: nmiPending=%b want 1", nmiPending); end
    instructionBoundary = 1'b1;
    tick();
    instructionBoundary = 1'b0;
    testsRun++; if (interruptRequest !== 1'b1 || vectorAddr !== 16'hFFFA) begin testsFailed++; $display("FAIL b2b_second: req=%b vec=%h want 1/FFFA", interruptRequest, vectorAddr); end
    interruptAck = 1'b1;
    tick();
    interruptAck = 1'b0;
    testsRun++; if (nmiPending !== 1'b0) begin testsFailed++; $display("FAIL b2b_final_pending: got %b want 0", nmiPending); end
  endtask

  task automatic test_ack_idle_irq_lost();
    interruptAck = 1'b1;
    tick();
    interruptAck = 1'b0;
    testsRun++; if (interruptRequest !== 1'b0) begin testsFailed++; $display("FAIL ack_idle_req: got %b want 0", interruptRequest); end
    testsRun++; if (vectorAddr !== 16'hFFFA) begin testsFailed++; $display("FAIL ack_idle_vector: got %h want FFFA", vectorAddr); end
    processStatusRegIFlag = 1'b0;
    nIrqPin = 1'b0;
    repeat (2) tick();
    nIrqPin = 1'b1;
    repeat (EFF_STAGES + 1) tick();
    instructionBoundary = 1'b1;
    tick();
    instructionBoundary = 1'b0;
    testsRun++; if (interruptRequest !== 1'b0) begin testsFailed++; $display("FAIL irq_lost_req: got %b want 0", interruptRequest); end
    testsRun++; if (vectorAddr !== 16'hFFFA) begin testsFailed++; $display("FAIL irq_lost_vector: got %h want FFFA", vectorAddr); end
  endtask

  initial begin
    testsRun              = 0;
    testsFailed           = 0;
    nrst                  = 1'b0;
    enableFFs             = 1'b1;
    nResPin               = 1'b1;
    nNmiPin               = 1'b1;
    nIrqPin               = 1'b1;
    processStatusRegIFlag = 1'b1;
    resetRunning          = 1'b0;
    instructionBoundary   = 1'b0;
    interruptAck          = 1'b0;

    test_reset();
    test_res_glitch();
    test_res_long();
    test_nmi_stalled();
    test_irq_masked();
    test_nmi_during_irq();
    test_reset_running();
    test_back_to_back();
    test_ack_idle_irq_lost();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/interrupt_request_ctrl.md
Name: interrupt_request_ctrl

Overview:
- Front end of the 6502-style reset/NMI/IRQ path: samples the external nRES/nNMI/nIRQ pins and decides when a reset or interrupt sequence starts.
- Produces the one-cycle `resetInitiated` pulse consumed by the reset-running control FF.
- Presents prioritised interrupt requests with a vector address to the instruction-sequencing logic at instruction boundaries.
- Honours the global `enableFFs` stall and the processor-status I flag.

Parameters:
- SYNC_STAGES, 2, flop stages on each external pin input (min 1).
- RES_HOLD_CYCLES, 2, consecutive enabled cycles synchronised nRES must be low before a reset is armed (min 1).

Ports:
- clk  input  1  system clock
- nrst  input  1  synchronous active-low reset
- enableFFs  input  1  global state-advance enable; low = stall
- nResPin  input  1  external reset request, active low, asynchronous
- nNmiPin  input  1  external NMI, falling-edge triggered, asynchronous
- nIrqPin  input  1  external IRQ, level, active low, asynchronous
- processStatusRegIFlag  input  1  I flag; 1 masks IRQ
- resetRunning  input  1  reset sequence in progress (from reset-running FF)
- instructionBoundary  input  1  high in the opcode-fetch cycle
- interruptAck  input  1  sequencer has fetched the vector; ends service
- resetInitiated  output  1  one-cycle pulse: begin reset sequence
- interruptRequest  output  1  NMI/IRQ sequence requested/in service
- nmiPending  output  1  latched NMI edge not yet serviced
- vectorAddr  output  16  vector low-byte address: FFFC reset, FFFA NMI, FFFE IRQ

Behaviour:
- Reset: `nrst` is synchronous and active low, sampled on posedge `clk`.
- Reset values:
  - FSM = RES_HOLD with hold counter saturated, so a power-on reset sequence follows.
  - `resetInitiated` = 0, `interruptRequest` = 0, `nmiPending` = 0, `vectorAddr` = 16'hFFFC.
  - Synchronisers load 1; NMI edge register loads 1.
- Synchronisers and the NMI edge register clock every cycle, independent of `enableFFs`.
- NMI edge: when the previous synced `nNmi` = 1 and the current = 0, set `nmiPending` (sticky) even if `enableFFs` = 0.
- All FSM, counter and output updates occur only when `enableFFs` = 1; otherwise they hold.
- Hold counter:
  - Increments (saturating at RES_HOLD_CYCLES) on each enabled cycle with synced `nRes` = 0.
  - Clears when synced `nRes` = 1.
- FSM states: IDLE, SERVICE, RES_HOLD.
- Any state -> RES_HOLD when the counter reaches RES_HOLD_CYCLES.
  - Clears `interruptRequest` and `nmiPending`.
  - Sets `vectorAddr` = FFFC.
  - Reset has absolute priority over all other transitions.
- RES_HOLD:
  - While synced `nRes` = 0, stay; no outputs except `vectorAddr` = FFFC.
  - First enabled cycle with synced `nRes` = 1: `resetInitiated` = 1 for exactly that cycle, go to IDLE.
- IDLE: when `instructionBoundary` = 1 and `resetRunning` = 0 and a request exists, go to SERVICE.
  - Set `interruptRequest` = 1 in the same registered update.
  - Latch `vectorAddr` by priority: NMI (`nmiPending`) -> FFFA; else IRQ (synced `nIrq` = 0 and I flag = 0) -> FFFE.
  - No request, or `resetRunning` = 1: stay in IDLE.
- SERVICE:
  - `interruptRequest` held high; `vectorAddr` frozen.
  - On `interruptAck` = 1, go to IDLE and drop `interruptRequest`.
  - If the serviced vector was FFFA, clear `nmiPending`. If a new NMI edge arrives in the same cycle, the set wins.
- An NMI edge during IRQ service stays pending and is taken at the next boundary.
- IRQ is level-sensitive and not latched: if deasserted before the boundary, it is lost.
- `interruptAck` while not in SERVICE is ignored.
- `resetInitiated` is never asserted on consecutive cycles.

Optional Feature:
- Macro: INTERRUPT_PIN_SYNC_EN.
- Defined: each pin passes through SYNC_STAGES flops.
- Undefined: each pin passes through one flop only (SYNC_STAGES ignored), giving one cycle less pin-to-decision latency; for simulation and test harnesses with synchronous stimulus.

Test Plan:
- Release `nrst`, pins high, `enableFFs` = 1 -> `resetInitiated` pulses for one cycle on the first enabled cycle after release; `vectorAddr` = FFFC; then IDLE.
- Drive `nResPin` low for 1 cycle (RES_HOLD_CYCLES = 2) -> no reset. Low for 4 cycles, then high -> single `resetInitiated` pulse SYNC_STAGES+1 cycles after the rise; `nmiPending` cleared.
- Pulse `nNmiPin` low for 1 cycle while `enableFFs` = 0, then enable, then `instructionBoundary` -> `nmiPending` = 1, `interruptRequest` = 1, `vectorAddr` = FFFA; after `interruptAck`, `nmiPending` = 0.
- Hold `nIrqPin` low with I = 1 across boundaries -> no request. Clear I -> request at next boundary with `vectorAddr` = FFFE.
- During IRQ SERVICE, NMI edge -> `vectorAddr` stays FFFE until ack; next boundary serves FFFA.
- `resetRunning` = 1 with NMI pending and a boundary -> no request; when `resetRunning` drops, the next boundary serves NMI.
